// File: rtl/free_list_bitmap_if.sv
// Allocation / release bundle for the bitmap free list.
// master: rename/commit side driving requests; slave: the free list itself.
interface free_list_bitmap_if #(
    parameter int unsigned NUM_ENTRIES = 64
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    // Allocation side (rename)
    logic             alloc_req;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_fire;

    // Release side (commit, two ports)
    logic             rel0_valid;
    logic [IDX_W-1:0] rel0_idx;
    logic             rel1_valid;
    logic [IDX_W-1:0] rel1_idx;

    // Status
    logic [CNT_W-1:0] free_count;
    logic             empty;
    logic             err_dbl_free;
    logic             err_range;

    modport master (
        output alloc_req,
        output rel0_valid,
        output rel0_idx,
        output rel1_valid,
        output rel1_idx,
        input  alloc_valid,
        input  alloc_idx,
        input  alloc_fire,
        input  free_count,
        input  empty,
        input  err_dbl_free,
        input  err_range
    );

    modport slave (
        input  alloc_req,
        input  rel0_valid,
        input  rel0_idx,
        input  rel1_valid,
        input  rel1_idx,
        output alloc_valid,
        output alloc_idx,
        output alloc_fire,
        output free_count,
        output empty,
        output err_dbl_free,
        output err_range
    );
endinterface

// File: rtl/free_list_bitmap.sv
// Bitmap free list for physical-register / slot tags.
// Allocation hands out the lowest-index free tag with zero latency; two commit
// ports return tags, which become allocatable the cycle after release.
module free_list_bitmap #(
    parameter int unsigned NUM_ENTRIES  = 64,
    parameter int unsigned NUM_RESERVED = 32
) (
    input logic                  clk,
    input logic                  rst,
    free_list_bitmap_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    // Reset map: architectural tags 0..NUM_RESERVED-1 start in use.
    function automatic logic [NUM_ENTRIES-1:0] reset_map();
        logic [NUM_ENTRIES-1:0] m;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            m[i] = (i >= NUM_RESERVED);
        end
        return m;
    endfunction

    localparam logic [NUM_ENTRIES-1:0] FREE_RST = reset_map();
    localparam logic [CNT_W-1:0]       CNT_RST  = CNT_W'(NUM_ENTRIES - NUM_RESERVED);

    // One-hot decode of a tag index; out-of-range indices decode to all zeros.
    function automatic logic [NUM_ENTRIES-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [NUM_ENTRIES-1:0] m;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            m[i] = (idx == IDX_W'(i));
        end
        return m;
    endfunction

    // Lowest-index set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    logic [NUM_ENTRIES-1:0] free_q, free_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_dbl_q, err_dbl_d;
    logic                   err_range_q, err_range_d;

    logic                   alloc_valid;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   alloc_fire;
    logic [NUM_ENTRIES-1:0] alloc_mask;

    logic                   rel0_in_range, rel1_in_range;
    logic [NUM_ENTRIES-1:0] rel0_mask, rel1_mask;
    logic                   rel0_hit_free, rel1_hit_free;
    logic                   rel1_dup;
    logic                   rel0_eff, rel1_eff;
    logic                   rel0_dbl, rel1_dbl;
    logic [NUM_ENTRIES-1:0] set_mask;

    // Range check only needs logic when the index space has unused codes.
    if (NUM_ENTRIES == (1 << IDX_W)) begin : g_pow2
        assign rel0_in_range = 1'b1;
        assign rel1_in_range = 1'b1;
    end else begin : g_npow2
        assign rel0_in_range = (32'(bus.rel0_idx) < NUM_ENTRIES);
        assign rel1_in_range = (32'(bus.rel1_idx) < NUM_ENTRIES);
    end

    // Allocation select: lowest free tag, purely from the registered bitmap.
    always_comb begin
        alloc_valid = |free_q;
        alloc_idx   = lowest_set(free_q);
        alloc_fire  = bus.alloc_req & alloc_valid;
        alloc_mask  = alloc_fire ? decode(alloc_idx) : '0;
    end

    // Release classification: effective, double free or out of range per port.
    always_comb begin
        rel0_mask     = decode(bus.rel0_idx);
        rel1_mask     = decode(bus.rel1_idx);
        rel0_hit_free = |(free_q & rel0_mask);
        rel1_hit_free = |(free_q & rel1_mask);
        // Port 1 repeating port 0's tag in the same cycle is the second release of it.
        rel1_dup      = bus.rel0_valid & bus.rel1_valid & (bus.rel0_idx == bus.rel1_idx);

        rel0_eff = bus.rel0_valid & rel0_in_range & ~rel0_hit_free;
        rel1_eff = bus.rel1_valid & rel1_in_range & ~rel1_hit_free & ~rel1_dup;
        rel0_dbl = bus.rel0_valid & rel0_in_range & rel0_hit_free;
        rel1_dbl = bus.rel1_valid & rel1_in_range & (rel1_hit_free | rel1_dup);

        set_mask = (rel0_eff ? rel0_mask : '0) | (rel1_eff ? rel1_mask : '0);
    end

    // Next state: effective releases only touch clear bits, so they never
    // collide with the allocated (free) bit.
    always_comb begin
        free_d      = (free_q & ~alloc_mask) | set_mask;
        cnt_d       = cnt_q - CNT_W'(alloc_fire) + CNT_W'(rel0_eff) + CNT_W'(rel1_eff);
        err_dbl_d   = rel0_dbl | rel1_dbl;
        err_range_d = (bus.rel0_valid & ~rel0_in_range) | (bus.rel1_valid & ~rel1_in_range);
    end

    // State registers; reset drops any in-flight strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q      <= FREE_RST;
            cnt_q       <= CNT_RST;
            err_dbl_q   <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            free_q      <= free_d;
            cnt_q       <= cnt_d;
            err_dbl_q   <= err_dbl_d;
            err_range_q <= err_range_d;
        end
    end

    assign bus.alloc_valid  = alloc_valid;
    assign bus.alloc_idx    = alloc_idx;
    assign bus.alloc_fire   = alloc_fire;
    assign bus.free_count   = cnt_q;
    assign bus.empty        = (cnt_q == '0);
    assign bus.err_dbl_free = err_dbl_q;
    assign bus.err_range    = err_range_q;
endmodule

// File: tb/tb_free_list_bitmap.sv
// Directed bench for free_list_bitmap: one task per scenario, inline checks.
// A second small instance (6 entries) exercises the out-of-range release path.
module tb_free_list_bitmap;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    free_list_bitmap_if #(.NUM_ENTRIES(64)) bus ();
    free_list_bitmap_if #(.NUM_ENTRIES(6))  sbus ();

    free_list_bitmap #(.NUM_ENTRIES(64), .NUM_RESERVED(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    free_list_bitmap #(.NUM_ENTRIES(6), .NUM_RESERVED(2)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic clear_inputs();
        bus.alloc_req  = 1'b0;
        bus.rel0_valid = 1'b0;
        bus.rel0_idx   = '0;
        bus.rel1_valid = 1'b0;
        bus.rel1_idx   = '0;
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++; if (bus.alloc_valid !== 1'b1) begin n_errors++;
            $display("FAIL %s alloc_valid got %b want 1", tag, bus.alloc_valid); end
        n_checks++; if (bus.alloc_idx !== 6'd32) begin n_errors++;
            $display("FAIL %s alloc_idx got %0d want 32", tag, bus.alloc_idx); end
        n_checks++; if (bus.free_count !== 7'd32) begin n_errors++;
            $display("FAIL %s free_count got %0d want 32", tag, bus.free_count); end
        n_checks++; if (bus.empty !== 1'b0) begin n_errors++;
            $display("FAIL %s empty got %b want 0", tag, bus.empty); end
        n_checks++; if (bus.err_dbl_free !== 1'b0 || bus.err_range !== 1'b0) begin n_errors++;
            $display("FAIL %s err got %b%b want 00", tag, bus.err_dbl_free, bus.err_range); end
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset_released");
    endtask

    task automatic test_range();
        sbus.rel0_valid = 1'b1; sbus.rel0_idx = 3'd7;
        @(negedge clk);
        sbus.rel0_valid = 1'b0;
        n_checks++; if (sbus.err_range !== 1'b1) begin n_errors++;
            $display("FAIL range_pulse err_range got %b want 1", sbus.err_range); end
        n_checks++; if (sbus.free_count !== 3'd4) begin n_errors++;
            $display("FAIL range_count free_count got %0d want 4", sbus.free_count); end
        @(negedge clk);
        n_checks++; if (sbus.err_range !== 1'b0) begin n_errors++;
            $display("FAIL range_drop err_range got %b want 0", sbus.err_range); end
        // port 0 legal (tag 0 in use), port 1 out of range
        sbus.rel0_valid = 1'b1; sbus.rel0_idx = 3'd0;
        sbus.rel1_valid = 1'b1; sbus.rel1_idx = 3'd6;
        @(negedge clk);
        sbus.rel0_valid = 1'b0; sbus.rel1_valid = 1'b0;
        n_checks++; if (sbus.free_count !== 3'd5 || sbus.alloc_idx !== 3'd0) begin n_errors++;
            $display("FAIL range_mixed count/idx got %0d/%0d want 5/0",
                     sbus.free_count, sbus.alloc_idx); end
        n_checks++; if (sbus.err_range !== 1'b1 || sbus.err_dbl_free !== 1'b0) begin n_errors++;
            $display("FAIL range_mixed_err got rng=%b dbl=%b want 1/0",
                     sbus.err_range, sbus.err_dbl_free); end
    endtask

    task automatic test_alloc_drain();
        for (int i = 0; i < 32; i++) begin
            bus.alloc_req = 1'b1;
            #1;
            n_checks++; if (bus.alloc_idx !== 6'(32 + i) || bus.alloc_fire !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_%0d idx/fire got %0d/%b want %0d/1",
                         i, bus.alloc_idx, bus.alloc_fire, 32 + i); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (bus.alloc_valid !== 1'b0 || bus.alloc_fire !== 1'b0) begin n_errors++;
            $display("FAIL drain_empty valid/fire got %b/%b want 0/0",
                     bus.alloc_valid, bus.alloc_fire); end
        n_checks++; if (bus.empty !== 1'b1 || bus.free_count !== 7'd0) begin n_errors++;
            $display("FAIL drain_count empty/count got %b/%0d want 1/0",
                     bus.empty, bus.free_count); end
        n_checks++; if (bus.alloc_idx !== 6'd0) begin n_errors++;
            $display("FAIL drain_idx alloc_idx got %0d want 0", bus.alloc_idx); end
        @(negedge clk);
        bus.alloc_req = 1'b0;
        n_checks++; if (bus.free_count !== 7'd0) begin n_errors++;
            $display("FAIL empty_req free_count got %0d want 0", bus.free_count); end
    endtask

    task automatic test_refill();
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd40;
        bus.rel1_valid = 1'b1; bus.rel1_idx = 6'd35;
        #1;
        n_checks++; if (bus.alloc_valid !== 1'b0) begin n_errors++;
            $display("FAIL refill_same_cycle alloc_valid got %b want 0", bus.alloc_valid); end
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.alloc_idx !== 6'd35 || bus.free_count !== 7'd2) begin n_errors++;
            $display("FAIL refill idx/count got %0d/%0d want 35/2",
                     bus.alloc_idx, bus.free_count); end
        bus.alloc_req = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.alloc_idx !== 6'd40 || bus.free_count !== 7'd1) begin n_errors++;
            $display("FAIL refill_next idx/count got %0d/%0d want 40/1",
                     bus.alloc_idx, bus.free_count); end
        @(negedge clk);
        bus.alloc_req = 1'b0;
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++;
            $display("FAIL refill_drain empty got %b want 1", bus.empty); end
    endtask

    task automatic test_double_free();
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd50;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.free_count !== 7'd1 || bus.err_dbl_free !== 1'b0) begin n_errors++;
            $display("FAIL dbl_first count/err got %0d/%b want 1/0",
                     bus.free_count, bus.err_dbl_free); end
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd50;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.err_dbl_free !== 1'b1 || bus.free_count !== 7'd1) begin n_errors++;
            $display("FAIL dbl_again err/count got %b/%0d want 1/1",
                     bus.err_dbl_free, bus.free_count); end
        @(negedge clk);
        n_checks++; if (bus.err_dbl_free !== 1'b0) begin n_errors++;
            $display("FAIL dbl_pulse err_dbl_free got %b want 0", bus.err_dbl_free); end
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd10;
        bus.rel1_valid = 1'b1; bus.rel1_idx = 6'd10;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.free_count !== 7'd2 || bus.err_dbl_free !== 1'b1) begin n_errors++;
            $display("FAIL dbl_dup count/err got %0d/%b want 2/1",
                     bus.free_count, bus.err_dbl_free); end
        n_checks++; if (bus.alloc_idx !== 6'd10) begin n_errors++;
            $display("FAIL dbl_dup_idx alloc_idx got %0d want 10", bus.alloc_idx); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_seq [6];
        exp_seq = '{6'd11, 6'd12, 6'd20, 6'd30, 6'd50, 6'd60};
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd20;
        bus.rel1_valid = 1'b1; bus.rel1_idx = 6'd30;
        @(negedge clk);
        clear_inputs();
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd60;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.free_count !== 7'd5 || bus.alloc_idx !== 6'd10) begin n_errors++;
            $display("FAIL b2b_setup count/idx got %0d/%0d want 5/10",
                     bus.free_count, bus.alloc_idx); end
        bus.alloc_req  = 1'b1;
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd11;
        bus.rel1_valid = 1'b1; bus.rel1_idx = 6'd12;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.free_count !== 7'd6 || bus.err_dbl_free !== 1'b0) begin n_errors++;
            $display("FAIL b2b_count count/err got %0d/%b want 6/0",
                     bus.free_count, bus.err_dbl_free); end
        // draining shows the bitmap holds exactly the tags the count claims
        for (int i = 0; i < 6; i++) begin
            bus.alloc_req = 1'b1;
            #1;
            n_checks++; if (bus.alloc_idx !== exp_seq[i]) begin n_errors++;
                $display("FAIL b2b_drain_%0d alloc_idx got %0d want %0d",
                         i, bus.alloc_idx, exp_seq[i]); end
            @(negedge clk);
        end
        bus.alloc_req = 1'b0;
        n_checks++; if (bus.empty !== 1'b1 || bus.alloc_valid !== 1'b0) begin n_errors++;
            $display("FAIL b2b_empty empty/valid got %b/%b want 1/0",
                     bus.empty, bus.alloc_valid); end
    endtask

    task automatic test_alloc_rel_same();
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd5;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.alloc_idx !== 6'd5 || bus.free_count !== 7'd1) begin n_errors++;
            $display("FAIL same_setup idx/count got %0d/%0d want 5/1",
                     bus.alloc_idx, bus.free_count); end
        bus.alloc_req  = 1'b1;
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd5;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.free_count !== 7'd0 || bus.alloc_valid !== 1'b0) begin n_errors++;
            $display("FAIL same_alloc count/valid got %0d/%b want 0/0",
                     bus.free_count, bus.alloc_valid); end
        n_checks++; if (bus.err_dbl_free !== 1'b1) begin n_errors++;
            $display("FAIL same_dbl err_dbl_free got %b want 1", bus.err_dbl_free); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.alloc_req = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (bus.alloc_idx !== 6'd42 || bus.free_count !== 7'd22) begin n_errors++;
            $display("FAIL mid_before idx/count got %0d/%0d want 42/22",
                     bus.alloc_idx, bus.free_count); end
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd33;
        #2 rst = 1'b1;
        #1;
        check_reset_state("mid_async");
        @(negedge clk);
        check_reset_state("mid_held");
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full();
        for (int k = 0; k < 16; k++) begin
            bus.rel0_valid = 1'b1; bus.rel0_idx = 6'(2 * k);
            bus.rel1_valid = 1'b1; bus.rel1_idx = 6'(2 * k + 1);
            @(negedge clk);
        end
        clear_inputs();
        n_checks++; if (bus.free_count !== 7'd64 || bus.alloc_idx !== 6'd0) begin n_errors++;
            $display("FAIL full count/idx got %0d/%0d want 64/0",
                     bus.free_count, bus.alloc_idx); end
        bus.rel0_valid = 1'b1; bus.rel0_idx = 6'd0;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.err_dbl_free !== 1'b1 || bus.free_count !== 7'd64) begin n_errors++;
            $display("FAIL full_dbl err/count got %b/%0d want 1/64",
                     bus.err_dbl_free, bus.free_count); end
        bus.alloc_req = 1'b1;
        @(negedge clk);
        bus.alloc_req = 1'b0;
        n_checks++; if (bus.free_count !== 7'd63 || bus.alloc_idx !== 6'd1) begin n_errors++;
            $display("FAIL full_alloc count/idx got %0d/%0d want 63/1",
                     bus.free_count, bus.alloc_idx); end
    endtask

    initial begin
        clear_inputs();
        sbus.alloc_req  = 1'b0;
        sbus.rel0_valid = 1'b0;
        sbus.rel0_idx   = '0;
        sbus.rel1_valid = 1'b0;
        sbus.rel1_idx   = '0;
        test_reset();
        test_range();
        test_alloc_drain();
        test_refill();
        test_double_free();
        test_back_to_back();
        test_alloc_rel_same();
        test_reset_mid();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
